uart_tx_fifo: RTL and testbench

//  Buffered front-end for uart_tx: accepts bytes from a producer via a push

---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_tx: buffers producer pushes and issues one
// byte per frame through a start/wait handshake on tx_start, tx_busy and tx_done.
module uart_tx_fifo #(
  parameter  int DATAWIDTH = 8,
  parameter  int DEPTH     = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic                 tx_start,
  output logic [DATAWIDTH-1:0] tx_din,
  input  logic                 tx_busy,
  input  logic                 tx_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATAWIDTH-1:0] tx_din_q, tx_din_d;
  logic                 overflow_q, overflow_d;
  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic                 push, pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // never makes room for a push against a full FIFO.
  always_comb begin
    push       = wr_en && !full;
    overflow_d = wr_en && full;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    rd_ptr_d   = rd_ptr_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_din_d   = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + AW'(1);
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model of stored bytes plus a simple
// uart_tx responder; directed tables, corner sequences and random traffic.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, wr_en, hold_busy, tx_busy_m, tx_done;
  logic [DW-1:0] wr_data;
  logic          full, empty, overflow, tx_start;
  logic [4:0]    count;
  logic [DW-1:0] tx_din;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] mq[$];
  int            frame_cnt = 0;
  int            frame_min = 1;
  int            frame_max = 4;
  logic [DW-1:0] frame_byte = '0;
  int            start_cnt = 0;
  int            max_cnt = 0;

  typedef struct {
    logic          we;
    logic [DW-1:0] d;
    int            cnt;
    logic          full;
    logic          ovf;
  } vec_t;
  vec_t vec [18];

  uart_tx_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_din   (tx_din),
    .tx_busy  (tx_busy_m | hold_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then update the model and the
  // uart_tx stand-in from what is visible at the falling edge.
  task automatic step(input logic we, input logic [DW-1:0] d);
    int   prev;
    logic ovf_e;
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    prev  = mq.size();
    ovf_e = 1'b0;
    if (tx_start) begin
      start_cnt++;
      chk("start_while_busy", (frame_cnt != 0) || hold_busy, 0);
      chk("start_nonempty", prev > 0, 1);
      if (prev > 0) chk("tx_din_order", tx_din, mq.pop_front());
    end
    if (we && !reset) begin
      if (prev < DEPTH) mq.push_back(d);
      else ovf_e = 1'b1;
    end
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, ovf_e);
    if (int'(count) > max_cnt) max_cnt = count;
    tx_done = 1'b0;
    if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        chk("tx_din_held", tx_din, frame_byte);
        tx_busy_m = 1'b0;
        tx_done   = 1'b1;
      end
    end else if (tx_start) begin
      frame_cnt  = $urandom_range(frame_max, frame_min);
      frame_byte = tx_din;
      tx_busy_m  = 1'b1;
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mq.size() > 0 || frame_cnt > 0) && n < budget) begin
      step(1'b0, '0);
      n++;
    end
    chk("drain_in_budget", (mq.size() == 0) && (frame_cnt == 0), 1);
  endtask

  initial begin
    int s;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; hold_busy = 1'b0;
    tx_busy_m = 1'b0; tx_done = 1'b0;

    for (int i = 0; i < 18; i++) begin
      vec[i].we   = (i < 17);
      vec[i].d    = DW'(i);
      vec[i].cnt  = (i + 1 > DEPTH) ? DEPTH : i + 1;
      vec[i].full = (i >= DEPTH - 1);
      vec[i].ovf  = (i == DEPTH);
    end

    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_din", tx_din, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;

    // single byte
    s = start_cnt;
    step(1'b1, 8'hC1);
    drain(100);
    chk("t1_starts", start_cnt - s, 1);
    chk("t1_din", tx_din, 8'hC1);
    chk("t1_empty", empty, 1);

    // four back-to-back pushes
    s = start_cnt; max_cnt = 0;
    step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'h33); step(1'b1, 8'h44);
    drain(200);
    chk("t2_peak", max_cnt, 3);
    chk("t2_starts", start_cnt - s, 4);

    // pointer wrap: 6 then 14
    s = start_cnt;
    for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom));
    drain(300);
    for (int i = 0; i < 14; i++) step(1'b1, DW'($urandom));
    drain(600);
    chk("t4_starts", start_cnt - s, 20);
    chk("t4_count", count, 0);

    // fill while uart_tx is held busy, one push past full
    hold_busy = 1'b1;
    s = start_cnt;
    for (int i = 0; i < 18; i++) begin
      step(vec[i].we, vec[i].d);
      chk("t3_count", count, vec[i].cnt);
      chk("t3_full", full, vec[i].full);
      chk("t3_ovf", overflow, vec[i].ovf);
      chk("t3_no_start", tx_start, 0);
    end

    // full FIFO: push and pop on the same edge
    hold_busy = 1'b0;
    step(1'b1, 8'hAA);
    chk("t6_count", count, 15);
    chk("t6_ovf", overflow, 1);
    chk("t6_start", tx_start, 1);
    chk("t6_din", tx_din, 8'h00);
    drain(600);
    chk("t3_starts", start_cnt - s, 16);

    // random traffic
    frame_min = 1; frame_max = 6;
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 99) < 40, DW'($urandom));
    drain(2000);

    // reset in the middle of a frame with three bytes queued
    frame_min = 8; frame_max = 8;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h50 + i));
    chk("t5_pre_count", count, 3);
    #2 reset = 1'b1;
    #1;
    chk("t5_tx_start", tx_start, 0);
    chk("t5_tx_din", tx_din, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    mq.delete();
    frame_byte = '0;
    step(1'b0, '0);
    step(1'b0, '0);
    reset = 1'b0;
    s = start_cnt;
    for (int i = 0; i < 40; i++) step(1'b0, '0);
    chk("t5_no_start", start_cnt - s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
